// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: per-item prices and stock, saturating credit,
// coin rejection, cancel/refund and sold-out flags. Optional idle refund: VM_TIMEOUT_REFUND_EN.
module vending_machine_multi #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd15, 8'd60, 8'd40, 8'd20},
    parameter int MAX_CREDIT = 200,
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r_05,
    input  logic                 r_10,
    input  logic                 r_20,
    input  logic [NUM_ITEMS-1:0] select,
    input  logic                 cancel,
    input  logic                 restock,
    output logic [NUM_ITEMS-1:0] dispense,
    output logic [CREDIT_W-1:0]  change,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 coin_reject,
    output logic                 deny
);

    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CREDIT_W-1:0]  credit_nxt;
    logic [CREDIT_W-1:0]  change_nxt;
    logic                 change_valid_nxt;
    logic [NUM_ITEMS-1:0] dispense_nxt;
    logic [NUM_ITEMS-1:0] sold_out_nxt;
    logic                 coin_reject_nxt;
    logic                 deny_nxt;

    logic [STOCK_W-1:0]  stock     [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_nxt [NUM_ITEMS];
    logic [CREDIT_W-1:0] price     [NUM_ITEMS];

    genvar g;
    generate
        for (g = 0; g < NUM_ITEMS; g++) begin : g_price
            assign price[g] = PRICES[g*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    // Coin decode: a coin is only usable when exactly one line is high and it fits.
    logic                coin_any;
    logic                coin_multi;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W:0]   coin_sum;

    assign coin_any   = r_05 | r_10 | r_20;
    assign coin_multi = (r_05 & r_10) | (r_05 & r_20) | (r_10 & r_20);
    assign coin_sum   = {1'b0, credit} + {1'b0, coin_value};
    assign coin_ok    = coin_any && !coin_multi && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    always_comb begin
        coin_value = '0;
        if (r_05) begin
            coin_value = CREDIT_W'(5);
        end else if (r_10) begin
            coin_value = CREDIT_W'(10);
        end else if (r_20) begin
            coin_value = CREDIT_W'(20);
        end
    end

    // Selection decode: lowest-index request wins.
    logic                sel_any;
    logic                sel_ok;
    logic [IDX_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] sel_price;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (select[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_any   = |select;
    assign sel_price = price[sel_idx];
    assign sel_ok    = (credit >= sel_price) && (stock[sel_idx] != '0);

`ifdef VM_TIMEOUT_REFUND_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer, timer_nxt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nxt        = state;
        credit_nxt       = credit;
        change_nxt       = '0;
        change_valid_nxt = 1'b0;
        dispense_nxt     = '0;
        coin_reject_nxt  = 1'b0;
        deny_nxt         = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_nxt[i] = stock[i];
        end
`ifdef VM_TIMEOUT_REFUND_EN
        timer_nxt = '0;
`endif

        case (state)
            S_VEND: begin
                state_nxt       = S_IDLE;
                coin_reject_nxt = coin_any;
            end
            default: begin
                if (cancel && state == S_CREDIT) begin
                    change_nxt       = credit;
                    change_valid_nxt = 1'b1;
                    credit_nxt       = '0;
                    state_nxt        = S_IDLE;
                    coin_reject_nxt  = coin_any;
                end else if (sel_any) begin
                    if (sel_ok) begin
                        dispense_nxt[sel_idx] = 1'b1;
                        change_nxt            = credit - sel_price;
                        change_valid_nxt      = 1'b1;
                        credit_nxt            = '0;
                        stock_nxt[sel_idx]    = stock[sel_idx] - STOCK_W'(1);
                        state_nxt             = S_VEND;
                    end else begin
                        deny_nxt = 1'b1;
                    end
                    coin_reject_nxt = coin_any;
                end else if (coin_any) begin
                    if (coin_ok) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = S_CREDIT;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end else if (restock && !cancel && state == S_IDLE) begin
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        stock_nxt[i] = STOCK_W'(INIT_STOCK);
                    end
                end
            end
        endcase

`ifdef VM_TIMEOUT_REFUND_EN
        // Only a quiet cycle that stays in CREDIT advances the idle timer.
        if (state == S_CREDIT && state_nxt == S_CREDIT && !sel_any && !coin_ok) begin
            if (timer >= TMR_W'(TIMEOUT_CYCLES - 1)) begin
                change_nxt       = credit;
                change_valid_nxt = 1'b1;
                credit_nxt       = '0;
                state_nxt        = S_IDLE;
            end else begin
                timer_nxt = timer + TMR_W'(1);
            end
        end
`endif

        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out_nxt[i] = (stock_nxt[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            dispense     <= '0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            sold_out     <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
`ifdef VM_TIMEOUT_REFUND_EN
            timer <= '0;
`endif
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            change       <= change_nxt;
            change_valid <= change_valid_nxt;
            dispense     <= dispense_nxt;
            coin_reject  <= coin_reject_nxt;
            deny         <= deny_nxt;
            sold_out     <= sold_out_nxt;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= stock_nxt[i];
            end
`ifdef VM_TIMEOUT_REFUND_EN
            timer <= timer_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: reference model pushes expected output events,
// a negedge monitor pops and compares them; credit and sold_out are checked directly.
module tb_vending_machine_multi;

    localparam int TB_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_05, r_10, r_20;
    logic [3:0] select;
    logic       cancel, restock;
    logic [3:0] dispense;
    logic [7:0] change;
    logic       change_valid;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       coin_reject, deny;

    vending_machine_multi #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .r_05(r_05), .r_10(r_10), .r_20(r_20),
        .select(select), .cancel(cancel), .restock(restock),
        .dispense(dispense), .change(change), .change_valid(change_valid),
        .credit(credit), .sold_out(sold_out), .coin_reject(coin_reject), .deny(deny)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Event layout: {dispense[3:0], change_valid, change[7:0], coin_reject, deny}
    logic [14:0] exp_q[$];
    logic [14:0] mon_ev;

    int m_credit;
    int m_stock[4];
    int m_tmr;
    bit m_vend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int price_of(input int idx);
        case (idx)
            0: return 20;
            1: return 40;
            2: return 60;
            default: return 15;
        endcase
    endfunction

    function automatic logic [3:0] model_sold();
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (m_stock[i] == 0);
        return s;
    endfunction

    always @(negedge clk) begin
        mon_ev = {dispense, change_valid, change, coin_reject, deny};
        if (mon_ev != '0) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'(mon_ev), 32'd0);
            else check("out_event", 32'(mon_ev), 32'(exp_q.pop_front()));
        end
    end

    task automatic model_reset();
        m_credit = 0;
        m_tmr    = 0;
        m_vend   = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
    endtask

    // c = {r_20, r_10, r_05}
    task automatic step(input logic [2:0] c, input logic [3:0] sel, input logic can, input logic rs);
        logic [3:0] e_disp;
        logic [7:0] e_chg;
        logic       e_cv, e_rej, e_deny;
        int         ncoin, val, idx;
        bit         coin_ok, was_credit;
        e_disp = '0; e_chg = '0; e_cv = 0; e_rej = 0; e_deny = 0; coin_ok = 0;
        ncoin = int'(c[0]) + int'(c[1]) + int'(c[2]);
        val = c[0] ? 5 : (c[1] ? 10 : 20);
        idx = -1;
        for (int i = 3; i >= 0; i--) if (sel[i]) idx = i;
        was_credit = !m_vend && m_credit > 0;
        if (m_vend) begin
            m_vend = 0;
            e_rej  = (ncoin > 0);
        end else if (can && m_credit > 0) begin
            e_cv = 1; e_chg = 8'(m_credit); m_credit = 0;
            e_rej = (ncoin > 0);
        end else if (idx >= 0) begin
            if (m_credit >= price_of(idx) && m_stock[idx] > 0) begin
                e_disp[idx] = 1'b1;
                e_cv = 1; e_chg = 8'(m_credit - price_of(idx));
                m_credit = 0; m_stock[idx]--; m_vend = 1;
            end else begin
                e_deny = 1;
            end
            e_rej = (ncoin > 0);
        end else if (ncoin > 1 || (ncoin == 1 && m_credit + val > 200)) begin
            e_rej = 1;
        end else if (ncoin == 1) begin
            m_credit += val; coin_ok = 1;
        end else if (rs && !can && m_credit == 0) begin
            for (int i = 0; i < 4; i++) m_stock[i] = 5;
        end
`ifdef VM_TIMEOUT_REFUND_EN
        if (was_credit && !m_vend && m_credit > 0) begin
            if (idx >= 0 || coin_ok) m_tmr = 0;
            else if (m_tmr == TB_TIMEOUT - 1) begin
                e_cv = 1; e_chg = 8'(m_credit); m_credit = 0; m_tmr = 0;
            end else m_tmr++;
        end else m_tmr = 0;
`endif
        if ({e_disp, e_cv, e_chg, e_rej, e_deny} != '0)
            exp_q.push_back({e_disp, e_cv, e_chg, e_rej, e_deny});
        {r_20, r_10, r_05} = c; select = sel; cancel = can; restock = rs;
        @(posedge clk); #1;
        {r_20, r_10, r_05} = 3'b000; select = '0; cancel = 1'b0; restock = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_credit"}, 32'(credit), 32'(m_credit));
        check({tag, "_sold_out"}, 32'(sold_out), 32'(model_sold()));
    endtask

    initial begin
        reset = 1'b1; r_05 = 0; r_10 = 0; r_20 = 0; select = '0; cancel = 0; restock = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_credit", 32'(credit), 32'd0);
        check("reset_sold_out", 32'(sold_out), 32'd0);
        check("reset_outputs", 32'({dispense, change_valid, change, coin_reject, deny}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Exact-price vend of item 0 gives change 0 with change_valid.
        step(3'b100, 4'b0000, 0, 0);
        step(3'b000, 4'b0001, 0, 0);
        idle(1);
        check_state("vend0");
        check("vend0_credit_const", 32'(credit), 32'd0);

        // 60 rupees for item 1 (40) -> change 20.
        repeat (3) step(3'b100, 4'b0000, 0, 0);
        step(3'b000, 4'b0010, 0, 0);
        idle(1);
        check_state("vend1");

        // Insufficient credit is denied, credit kept, then cancelled.
        step(3'b010, 4'b0000, 0, 0);
        step(3'b000, 4'b0100, 0, 0);
        check_state("deny");
        check("deny_credit_const", 32'(credit), 32'd10);
        step(3'b000, 4'b0000, 1, 0);
        idle(1);
        check_state("cancel");

        // Drain item 3, then deny, ignored restock in CREDIT, refund, restock in IDLE.
        for (int k = 0; k < 5; k++) begin
            step(3'b100, 4'b0000, 0, 0);
            step(3'b000, 4'b1000, 0, 0);
            idle(1);
        end
        check_state("drain3");
        check("drain3_sold_const", 32'(sold_out), 32'h8);
        step(3'b100, 4'b0000, 0, 0);
        step(3'b000, 4'b1000, 0, 0);
        step(3'b000, 4'b0000, 0, 1);
        idle(1);
        check_state("restock_ignored");
        step(3'b000, 4'b0000, 1, 0);
        step(3'b000, 4'b0000, 0, 1);
        idle(1);
        check_state("restock");
        check("restock_sold_const", 32'(sold_out), 32'h0);

        // Saturation: 190, reject 20, reject double coin, accept 10 to exactly 200, reject 5.
        repeat (9) step(3'b100, 4'b0000, 0, 0);
        step(3'b010, 4'b0000, 0, 0);
        step(3'b100, 4'b0000, 0, 0);
        step(3'b011, 4'b0000, 0, 0);
        check_state("sat190");
        check("sat190_const", 32'(credit), 32'd190);
        step(3'b010, 4'b0000, 0, 0);
        step(3'b001, 4'b0000, 0, 0);
        check_state("sat200");
        step(3'b000, 4'b0000, 1, 0);
        idle(1);

        // Coin alongside an accepted select, coin during VEND, lowest-index select.
        step(3'b100, 4'b0000, 0, 0);
        step(3'b010, 4'b0001, 0, 0);
        step(3'b001, 4'b0000, 0, 0);
        repeat (3) step(3'b100, 4'b0000, 0, 0);
        step(3'b000, 4'b1110, 0, 0);
        idle(1);
        step(3'b000, 4'b0000, 1, 0);
        check_state("lowest_idx");

        // Idle credit: held without the refund timer, refunded after timeout with it.
        step(3'b010, 4'b0000, 0, 0);
        idle(TB_TIMEOUT + 4);
        check_state("timeout");
`ifdef VM_TIMEOUT_REFUND_EN
        check("timeout_credit_const", 32'(credit), 32'd0);
`else
        check("hold_credit_const", 32'(credit), 32'd10);
`endif
        step(3'b000, 4'b0000, 1, 0);
        idle(1);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            logic [2:0] c;
            logic [3:0] s;
            case ($urandom_range(0, 9))
                4: c = 3'b001;
                5: c = 3'b010;
                6, 7: c = 3'b100;
                8: c = 3'b011 << $urandom_range(0, 1);
                9: c = 3'b111;
                default: c = 3'b000;
            endcase
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            step(c, s, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
            @(negedge clk);
            check("rand_credit", 32'(credit), 32'(m_credit));
        end
        step(3'b000, 4'b0000, 1, 0);
        idle(2);

        // Reset at credit 40 with a would-be vend in the same cycle: nothing emerges.
        step(3'b100, 4'b0000, 0, 0);
        step(3'b100, 4'b0000, 0, 0);
        reset = 1'b1; select = 4'b0001;
        @(posedge clk); #1;
        reset = 1'b0; select = '0;
        model_reset();
        @(negedge clk);
        check("midreset_credit", 32'(credit), 32'd0);
        check("midreset_outputs", 32'({dispense, change_valid, change, coin_reject, deny}), 32'd0);
        idle(2);
        check_state("post_reset");

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the 3-item vending controller.
- Supports NUM_ITEMS products, each with its own compile-time price and per-item stock counter.
- Adds credit saturation, coin rejection, cancel/refund, sold-out flags, a denial pulse and a qualified change output.
- Sits between the coin acceptor/keypad front-end and the dispense actuators.

Parameters:
- NUM_ITEMS, 4, number of products (1..8).
- CREDIT_W, 8, width of credit/change/price values, in rupees.
- PRICES, {8'd15,8'd60,8'd40,8'd20}, packed NUM_ITEMS*CREDIT_W vector; item i occupies bits [i*CREDIT_W +: CREDIT_W]. Every price must be nonzero and a multiple of 5.
- MAX_CREDIT, 200, highest credit accepted; must be < 2**CREDIT_W.
- STOCK_W, 4, width of each stock counter.
- INIT_STOCK, 5, stock per item after reset or restock.
- TIMEOUT_CYCLES, 1000, idle-refund timeout; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r_05  in  1  5-rupee coin pulse.
- r_10  in  1  10-rupee coin pulse.
- r_20  in  1  20-rupee coin pulse.
- select  in  NUM_ITEMS  product request, level-sampled each cycle.
- cancel  in  1  refund request.
- restock  in  1  reload all stock counters to INIT_STOCK.
- dispense  out  NUM_ITEMS  one-hot, one-cycle vend pulse.
- change  out  CREDIT_W  change/refund amount; valid only when change_valid=1, otherwise 0.
- change_valid  out  1  one-cycle qualifier for change.
- credit  out  CREDIT_W  current accumulated credit (registered).
- sold_out  out  NUM_ITEMS  bit i=1 while stock[i]==0.
- coin_reject  out  1  one-cycle pulse: the coin presented last cycle was returned.
- deny  out  1  one-cycle pulse: the selection made last cycle was refused.

Behaviour:
- Reset (synchronous; also mid-transaction):
  - credit=0, every stock=INIT_STOCK, state=IDLE.
  - dispense, change, change_valid, coin_reject, deny and sold_out all 0.
  - Any pending vend or refund is dropped with no pulse.
- FSM states:
  - IDLE: credit==0.
  - CREDIT: credit>0.
  - VEND: one-cycle output state.
- All outputs are registered. A decision made on edge N shows on outputs in cycle N+1.
- Per-cycle priority in IDLE/CREDIT: cancel > select > coin > restock.
- Coin handling:
  - Value = 5/10/20 for exactly one of r_05/r_10/r_20 high.
  - More than one coin bit high: reject all of them, coin_reject=1 next cycle, credit unchanged.
  - credit+value > MAX_CREDIT: reject the coin, coin_reject=1.
  - Otherwise credit <= credit+value; IDLE->CREDIT.
  - A coin in the same cycle as an accepted select or cancel is rejected.
  - A coin arriving while in VEND is rejected.
- Select:
  - The lowest-index set bit is the chosen item i; other set bits are ignored.
  - Accepted if credit >= PRICE[i] and stock[i] > 0. Next cycle (VEND):
    - dispense[i]=1;
    - change = credit-PRICE[i], change_valid=1 even when change is 0;
    - credit=0 and stock[i] decrements.
  - After VEND the next state is IDLE.
  - Insufficient credit or stock[i]==0: deny=1 next cycle; credit and state unchanged.
- Cancel:
  - In CREDIT: change=credit and change_valid=1 next cycle, credit=0, go to IDLE.
  - In IDLE: no effect, no pulse.
- VEND lasts exactly 1 cycle. select, cancel and restock are ignored during VEND.
- restock:
  - Honoured only in IDLE with no other input active.
  - sold_out reflects the new stock in the next cycle.
- Credit never exceeds MAX_CREDIT. Arithmetic is unsigned CREDIT_W bits with no wrap.
- sold_out[i] is registered and updates the cycle after stock changes.

Optional Feature:
- Macro: VM_TIMEOUT_REFUND_EN.
- Defined:
  - A timeout counter runs while in CREDIT.
  - It clears on any accepted coin and on any select, whether accepted or denied.
  - When it reaches TIMEOUT_CYCLES, the block performs an automatic cancel: change=credit, change_valid=1, credit=0, go to IDLE.
  - The counter is 0 on reset and in IDLE.
- Undefined: no counter is built; credit is held indefinitely.

Test Plan:
- Reset, then r_20 for 1 cycle, then select=4'b0001 -> dispense=4'b0001 for 1 cycle, change=0 with change_valid=1, credit=0.
- Three r_20 pulses (credit=60), then select=4'b0010 -> dispense[1]=1, change=20, change_valid=1, stock[1]=4.
- Credit=10, select=4'b0100 -> deny=1 for 1 cycle, credit stays 10. Then cancel -> change=10, change_valid=1, credit=0.
- Vend item 3 (price 15) five times with r_20 each time -> change=5 each time; after the 5th vend sold_out[3]=1; 6th attempt gives deny=1. restock in IDLE -> sold_out=0.
- Credit at 190, r_20 -> coin_reject=1, credit stays 190. r_05 and r_10 in the same cycle -> coin_reject=1, credit unchanged.
- Timeout (VM_TIMEOUT_REFUND_EN defined, TIMEOUT_CYCLES=8): r_10, then 8 idle cycles -> change=10, change_valid=1, credit=0.
- Reset mid-stream: reset asserted at credit=40 -> credit=0 next cycle, no change_valid.
